abs_diff_err_sweep: RTL

// - Consumer end of a generated approximate abs_diff circuit: exhaustively drives all
//   2^(2*OP_W) input vectors into the external combinational netlist and reads back

---
 rtl/abs_diff_pkg.sv | 21 ++
 rtl/abs_diff_err_acc.sv | 64 ++++++
 rtl/abs_diff_err_sweep.sv | 114 +++++++++++
 3 files changed

// File: rtl/abs_diff_pkg.sv
// Shared types and helpers for the approximate abs_diff error sweep harness.
package abs_diff_pkg;

   localparam int unsigned DEF_OP_W  = 2;
   localparam int unsigned DEF_OUT_W = 2;
   localparam int unsigned DEF_ET    = 3;
   localparam int unsigned N_VEC     = 1 << (2 * DEF_OP_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Exact |a-b|; callers widen operands into and truncate the result out of 16 bits.
   function automatic logic [15:0] exact_abs_diff(input logic [15:0] a, input logic [15:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/abs_diff_err_acc.sv
// Stage-2 of the sweep pipeline: error against exact |a-b| and running statistics.
module abs_diff_err_acc
   import abs_diff_pkg::*;
#(
   parameter int unsigned OP_W  = DEF_OP_W,
   parameter int unsigned OUT_W = DEF_OUT_W,
   parameter int unsigned ET    = DEF_ET
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    en,
   input  logic [2*OP_W-1:0]       vec,
   input  logic [OUT_W-1:0]        approx,
   output logic [OUT_W-1:0]        max_err,
   output logic [2*OP_W+OUT_W-1:0] err_sum,
   output logic [2*OP_W:0]         viol_cnt
);

   localparam int unsigned D_W   = OUT_W + 1;
   localparam int unsigned SUM_W = 2 * OP_W + OUT_W;
   localparam int unsigned CNT_W = 2 * OP_W + 1;
   localparam logic [D_W-1:0] ET_W = D_W'(ET);

   logic [OP_W-1:0]  a_c;
   logic [OP_W-1:0]  b_c;
   logic [OP_W-1:0]  exact_c;
   logic [D_W-1:0]   diff_c;
   logic [OUT_W-1:0] err_c;
   logic             viol_c;

   // Difference is formed one bit wider than the output word, then truncated.
   always_comb begin
      a_c     = vec[OP_W-1:0];
      b_c     = vec[2*OP_W-1:OP_W];
      exact_c = OP_W'(exact_abs_diff(16'(a_c), 16'(b_c)));
      if (D_W'(exact_c) >= D_W'(approx)) begin
         diff_c = D_W'(exact_c) - D_W'(approx);
      end else begin
         diff_c = D_W'(approx) - D_W'(exact_c);
      end
      err_c  = diff_c[OUT_W-1:0];
      viol_c = (D_W'(err_c) > ET_W);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_err  <= '0;
         err_sum  <= '0;
         viol_cnt <= '0;
      end else if (clr) begin
         max_err  <= '0;
         err_sum  <= '0;
         viol_cnt <= '0;
      end else if (en) begin
         if (err_c > max_err) begin
            max_err <= err_c;
         end
         err_sum  <= err_sum + SUM_W'(err_c);
         viol_cnt <= viol_cnt + CNT_W'(viol_c);
      end
   end

endmodule

// File: rtl/abs_diff_err_sweep.sv
// Exhaustive sweep of an external approximate abs_diff netlist with error statistics.
module abs_diff_err_sweep
   import abs_diff_pkg::*;
#(
   parameter int unsigned OP_W  = DEF_OP_W,
   parameter int unsigned OUT_W = DEF_OUT_W,
   parameter int unsigned ET    = DEF_ET
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   output logic [2*OP_W-1:0]       approx_in,
   input  logic [OUT_W-1:0]        approx_out,
   output logic                    busy,
   output logic                    done,
   output logic [OUT_W-1:0]        max_err,
   output logic [2*OP_W+OUT_W-1:0] err_sum,
   output logic [2*OP_W:0]         viol_cnt,
   output logic                    pass
);

   localparam int unsigned VEC_W = 2 * OP_W;
   localparam logic [VEC_W-1:0] VEC_LAST = '1;

   state_e           state;
   logic             drain_last;
   logic             cap_valid;
   logic [VEC_W-1:0] vec_q;
   logic [OUT_W-1:0] approx_q;
   logic             start_ok_c;

   assign start_ok_c = (state == IDLE) && start && !abort;

   // Sweep control plus stage-1 capture of the netlist response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         approx_in  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b1;
         drain_last <= 1'b0;
         cap_valid  <= 1'b0;
         vec_q      <= '0;
         approx_q   <= '0;
      end else begin
         done      <= 1'b0;
         cap_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start_ok_c) begin
                  state     <= SWEEP;
                  approx_in <= '0;
                  busy      <= 1'b1;
               end
            end
            SWEEP: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cap_valid <= 1'b1;
                  vec_q     <= approx_in;
                  approx_q  <= approx_out;
                  if (approx_in == VEC_LAST) begin
                     state      <= DRAIN;
                     drain_last <= 1'b0;
                  end else begin
                     approx_in <= approx_in + VEC_W'(1);
                  end
               end
            end
            DRAIN: begin
               // Two cycles: one for the final capture to accumulate, one to settle pass.
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (!drain_last) begin
                  drain_last <= 1'b1;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  pass  <= (viol_cnt == '0);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   abs_diff_err_acc #(
      .OP_W  (OP_W),
      .OUT_W (OUT_W),
      .ET    (ET)
   ) u_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (start_ok_c),
      .en       (cap_valid),
      .vec      (vec_q),
      .approx   (approx_q),
      .max_err  (max_err),
      .err_sum  (err_sum),
      .viol_cnt (viol_cnt)
   );

endmodule
